// File: rtl/id_ex_operand_stage_if.sv
// Bundle of ID-side, forwarding-source and EX-side signals around the ID/EX
// operand stage. The pipeline control (master) drives the ID slot, the
// EX/MEM and MEM/WB forwarding sources, hold and flush. The stage (slave)
// returns the stall request and the registered EX slot.
interface id_ex_operand_stage_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
);
    // ID slot
    logic                     id_valid;
    logic [ADDRESS_WIDTH-1:0] id_rs1;
    logic [ADDRESS_WIDTH-1:0] id_rs2;
    logic                     id_use1;
    logic                     id_use2;
    logic [DATA_WIDTH-1:0]    id_rd1;
    logic [DATA_WIDTH-1:0]    id_rd2;
    logic [ADDRESS_WIDTH-1:0] id_rd;
    logic                     id_reg_write;
    logic                     id_mem_read;
    // forwarding sources
    logic [ADDRESS_WIDTH-1:0] mem_rd;
    logic                     mem_reg_write;
    logic [DATA_WIDTH-1:0]    mem_result;
    logic [ADDRESS_WIDTH-1:0] wb_rd;
    logic                     wb_reg_write;
    logic [DATA_WIDTH-1:0]    wb_result;
    // pipeline control
    logic                     ex_hold;
    logic                     flush;
    logic                     id_stall;
    // EX slot
    logic                     ex_valid;
    logic [ADDRESS_WIDTH-1:0] ex_rs1;
    logic [ADDRESS_WIDTH-1:0] ex_rs2;
    logic [ADDRESS_WIDTH-1:0] ex_rd;
    logic                     ex_reg_write;
    logic                     ex_mem_read;
    logic [DATA_WIDTH-1:0]    ex_op1;
    logic [DATA_WIDTH-1:0]    ex_op2;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd1, id_rd2,
               id_rd, id_reg_write, id_mem_read,
               mem_rd, mem_reg_write, mem_result,
               wb_rd, wb_reg_write, wb_result,
               ex_hold, flush,
        input  id_stall, ex_valid, ex_rs1, ex_rs2, ex_rd,
               ex_reg_write, ex_mem_read, ex_op1, ex_op2
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd1, id_rd2,
               id_rd, id_reg_write, id_mem_read,
               mem_rd, mem_reg_write, mem_result,
               wb_rd, wb_reg_write, wb_result,
               ex_hold, flush,
        output id_stall, ex_valid, ex_rs1, ex_rs2, ex_rd,
               ex_reg_write, ex_mem_read, ex_op1, ex_op2
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: captures register operands with WB bypass, forwards
// EX/MEM and MEM/WB results onto the EX operands, and inserts one bubble on
// a load-use hazard. Flush beats hold, hold beats the load-use bubble.

// One source operand: owns its registered index and value, the capture-time
// WB bypass and the EX-time forwarding mux.
module id_ex_operand_lane #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] id_rs,
    input  logic [DW-1:0] id_data,
    input  logic [AW-1:0] mem_rd,
    input  logic          mem_reg_write,
    input  logic [DW-1:0] mem_result,
    input  logic [AW-1:0] wb_rd,
    input  logic          wb_reg_write,
    input  logic [DW-1:0] wb_result,
    input  logic          flush,
    input  logic          hold,
    input  logic          load_use,
    output logic [AW-1:0] ex_rs,
    output logic [DW-1:0] ex_op
);
    logic [AW-1:0] rs_q;
    logic [DW-1:0] op_q;
    logic [DW-1:0] cap_op;

    // Regfile writes on the edge, so a same-cycle WB to our source is stale in id_data.
    always_comb begin
        cap_op = id_data;
        if (wb_reg_write && (wb_rd == id_rs) && (id_rs != '0))
            cap_op = wb_result;
    end

    // EX forwarding: x0 is hardwired zero, MEM is younger than WB so it wins.
    always_comb begin
        ex_op = op_q;
        if (rs_q == '0)
            ex_op = '0;
        else if (mem_reg_write && (mem_rd == rs_q))
            ex_op = mem_result;
        else if (wb_reg_write && (wb_rd == rs_q))
            ex_op = wb_result;
    end

    // Operand register; on hold it re-latches the forwarded value so the
    // result survives its producer retiring past WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_q <= '0;
            op_q <= '0;
        end else if (flush) begin
            rs_q <= '0;
            op_q <= '0;
        end else if (hold) begin
            op_q <= ex_op;
        end else if (load_use) begin
            rs_q <= '0;
            op_q <= '0;
        end else begin
            rs_q <= id_rs;
            op_q <= cap_op;
        end
    end

    assign ex_rs = rs_q;
endmodule

module id_ex_operand_stage #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    id_ex_operand_stage_if.slave bus
);
    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int NUM_OPS = 2;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rd;
        logic          reg_write;
        logic          mem_read;
    } ex_ctrl_t;

    ex_ctrl_t ex_q;
    ex_ctrl_t id_ctrl;

    logic [NUM_OPS-1:0][AW-1:0] id_rs;
    logic [NUM_OPS-1:0][DW-1:0] id_data;
    logic [NUM_OPS-1:0]         id_use;
    logic [NUM_OPS-1:0][AW-1:0] ex_rs;
    logic [NUM_OPS-1:0][DW-1:0] ex_op;
    logic [NUM_OPS-1:0]         rs_hit;
    logic                       ex_reg_write;
    logic                       ex_mem_read;
    logic                       load_use;

    assign id_rs   = {bus.id_rs2, bus.id_rs1};
    assign id_data = {bus.id_rd2, bus.id_rd1};
    assign id_use  = {bus.id_use2, bus.id_use1};
    assign id_ctrl = '{valid: bus.id_valid, rd: bus.id_rd,
                       reg_write: bus.id_reg_write, mem_read: bus.id_mem_read};

    // Control bits only mean anything for a valid EX instruction.
    assign ex_reg_write = ex_q.valid & ex_q.reg_write;
    assign ex_mem_read  = ex_q.valid & ex_q.mem_read;

    // Load in EX whose result an ID source needs: its data only exists after MEM.
    always_comb begin
        for (int i = 0; i < NUM_OPS; i++)
            rs_hit[i] = id_use[i] && (id_rs[i] == ex_q.rd);
        load_use = ex_mem_read && (ex_q.rd != '0) && bus.id_valid && (|rs_hit);
    end

    // EX control register, same priority as the operand lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ex_q <= '0;
        else if (bus.flush)
            ex_q <= '0;
        else if (bus.ex_hold)
            ex_q <= ex_q;
        else if (load_use)
            ex_q <= '0;
        else
            ex_q <= id_ctrl;
    end

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
        id_ex_operand_lane #(.AW(AW), .DW(DW)) u_lane (
            .clk           (clk),
            .rst_n         (rst_n),
            .id_rs         (id_rs[i]),
            .id_data       (id_data[i]),
            .mem_rd        (bus.mem_rd),
            .mem_reg_write (bus.mem_reg_write),
            .mem_result    (bus.mem_result),
            .wb_rd         (bus.wb_rd),
            .wb_reg_write  (bus.wb_reg_write),
            .wb_result     (bus.wb_result),
            .flush         (bus.flush),
            .hold          (bus.ex_hold),
            .load_use      (load_use),
            .ex_rs         (ex_rs[i]),
            .ex_op         (ex_op[i])
        );
    end

    assign bus.id_stall     = !bus.flush && (bus.ex_hold || load_use);
    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_rd        = ex_q.rd;
    assign bus.ex_reg_write = ex_reg_write;
    assign bus.ex_mem_read  = ex_mem_read;
    assign bus.ex_rs1       = ex_rs[0];
    assign bus.ex_rs2       = ex_rs[1];
    assign bus.ex_op1       = ex_op[0];
    assign bus.ex_op2       = ex_op[1];
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a reference that
// tracks the instruction sitting in EX.
module tb_id_ex_operand_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    id_ex_operand_stage_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) bus ();

    id_ex_operand_stage #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: the instruction occupying EX, as plain fields.
    logic        m_valid, m_rw, m_mr;
    logic [4:0]  m_rd;
    logic [4:0]  m_rs [2];
    logic [31:0] m_op [2];

    function automatic logic [31:0] fwd(logic [4:0] rs, logic [31:0] held);
        if (rs == 5'd0) return 32'd0;
        if (bus.mem_reg_write && bus.mem_rd == rs) return bus.mem_result;
        if (bus.wb_reg_write && bus.wb_rd == rs) return bus.wb_result;
        return held;
    endfunction

    function automatic logic [31:0] cap(logic [4:0] rs, logic [31:0] rf);
        if (bus.wb_reg_write && bus.wb_rd == rs && rs != 5'd0) return bus.wb_result;
        return rf;
    endfunction

    function automatic logic hazard();
        logic need;
        need = (bus.id_use1 && bus.id_rs1 == m_rd) || (bus.id_use2 && bus.id_rs2 == m_rd);
        return m_valid && m_mr && m_rd != 5'd0 && bus.id_valid && need;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || bus.flush || (!bus.ex_hold && hazard())) begin
            m_valid <= 1'b0; m_rw <= 1'b0; m_mr <= 1'b0; m_rd <= 5'd0;
            m_rs[0] <= 5'd0; m_rs[1] <= 5'd0; m_op[0] <= 32'd0; m_op[1] <= 32'd0;
        end else if (bus.ex_hold) begin
            m_op[0] <= fwd(m_rs[0], m_op[0]);
            m_op[1] <= fwd(m_rs[1], m_op[1]);
        end else begin
            m_valid <= bus.id_valid; m_rw <= bus.id_reg_write; m_mr <= bus.id_mem_read;
            m_rd <= bus.id_rd; m_rs[0] <= bus.id_rs1; m_rs[1] <= bus.id_rs2;
            m_op[0] <= cap(bus.id_rs1, bus.id_rd1);
            m_op[1] <= cap(bus.id_rs2, bus.id_rd2);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("id_stall", 32'(bus.id_stall), 32'(!bus.flush && (bus.ex_hold || hazard())));
        chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
        chk("ex_rd", 32'(bus.ex_rd), 32'(m_rd));
        chk("ex_rs1", 32'(bus.ex_rs1), 32'(m_rs[0]));
        chk("ex_rs2", 32'(bus.ex_rs2), 32'(m_rs[1]));
        chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(m_valid && m_rw));
        chk("ex_mem_read", 32'(bus.ex_mem_read), 32'(m_valid && m_mr));
        chk("ex_op1", bus.ex_op1, fwd(m_rs[0], m_op[0]));
        chk("ex_op2", bus.ex_op2, fwd(m_rs[1], m_op[1]));
    end

    task automatic idle();
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_use1 = 0; bus.id_use2 = 0;
        bus.id_rd1 = 0; bus.id_rd2 = 0; bus.id_rd = 0; bus.id_reg_write = 0; bus.id_mem_read = 0;
        bus.mem_rd = 0; bus.mem_reg_write = 0; bus.mem_result = 0;
        bus.wb_rd = 0; bus.wb_reg_write = 0; bus.wb_result = 0;
        bus.ex_hold = 0; bus.flush = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                            input logic u2, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [4:0] rd, input logic ld);
        bus.id_valid = 1; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_use1 = u1; bus.id_use2 = u2;
        bus.id_rd1 = d1; bus.id_rd2 = d2; bus.id_rd = rd; bus.id_reg_write = 1; bus.id_mem_read = ld;
    endtask

    initial begin
        idle();
        // Reset state
        step(); step(); #1;
        chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_id_stall", 32'(bus.id_stall), 32'd0);
        chk("rst_ex_op1", bus.ex_op1, 32'd0);
        rst_n = 1'b1;
        step();

        // Simple capture
        id_instr(5'd3, 5'd0, 1, 0, 32'h11, 32'h0, 5'd5, 0);
        step(); idle(); #1;
        chk("cap_valid", 32'(bus.ex_valid), 32'd1);
        chk("cap_op1", bus.ex_op1, 32'h11);

        // EX/MEM forward, MEM beats WB
        id_instr(5'd5, 5'd0, 1, 0, 32'h0, 32'h0, 5'd6, 0);
        step(); idle();
        bus.mem_rd = 5'd5; bus.mem_reg_write = 1; bus.mem_result = 32'hAA;
        bus.wb_rd = 5'd5; bus.wb_reg_write = 1; bus.wb_result = 32'hBB; #1;
        chk("fwd_mem_wins", bus.ex_op1, 32'hAA);
        bus.mem_reg_write = 0; #1;
        chk("fwd_wb", bus.ex_op1, 32'hBB);
        step(); idle();

        // Load-use: one bubble, then WB forward
        id_instr(5'd0, 5'd0, 0, 0, 32'h0, 32'h0, 5'd7, 1);
        step();
        id_instr(5'd1, 5'd7, 0, 1, 32'h0, 32'h0, 5'd8, 0); #1;
        chk("lu_stall", 32'(bus.id_stall), 32'd1);
        step();
        bus.mem_rd = 5'd7; #1;
        chk("lu_bubble", 32'(bus.ex_valid), 32'd0);
        chk("lu_released", 32'(bus.id_stall), 32'd0);
        step(); idle();
        bus.wb_rd = 5'd7; bus.wb_reg_write = 1; bus.wb_result = 32'h99; #1;
        chk("lu_consumer", 32'(bus.ex_valid), 32'd1);
        chk("lu_op2", bus.ex_op2, 32'h99);
        step(); idle();

        // Capture bypass from WB
        id_instr(5'd4, 5'd0, 1, 0, 32'h0, 32'h0, 5'd9, 0);
        bus.wb_rd = 5'd4; bus.wb_reg_write = 1; bus.wb_result = 32'h55;
        step(); idle(); #1;
        chk("bypass_op1", bus.ex_op1, 32'h55);

        // Hold keeps a forwarded value after MEM retires
        id_instr(5'd6, 5'd0, 1, 0, 32'h0, 32'h0, 5'd9, 0);
        step();
        bus.ex_hold = 1; bus.mem_rd = 5'd6; bus.mem_reg_write = 1; bus.mem_result = 32'h77; #1;
        chk("hold_op1_a", bus.ex_op1, 32'h77);
        chk("hold_stall_a", 32'(bus.id_stall), 32'd1);
        step(); bus.mem_reg_write = 0; #1;
        chk("hold_op1_b", bus.ex_op1, 32'h77);
        step(); #1;
        chk("hold_op1_c", bus.ex_op1, 32'h77);
        chk("hold_stall_c", 32'(bus.id_stall), 32'd1);
        step(); idle();

        // Flush beats hold and load-use
        id_instr(5'd0, 5'd0, 0, 0, 32'h0, 32'h0, 5'd7, 1);
        step();
        id_instr(5'd7, 5'd0, 1, 0, 32'h0, 32'h0, 5'd2, 0);
        bus.ex_hold = 1; bus.flush = 1; #1;
        chk("flush_stall", 32'(bus.id_stall), 32'd0);
        step(); idle(); #1;
        chk("flush_valid", 32'(bus.ex_valid), 32'd0);

        // x0 never forwarded
        id_instr(5'd0, 5'd0, 1, 1, 32'h123, 32'h456, 5'd0, 0);
        step(); idle();
        bus.mem_rd = 0; bus.mem_reg_write = 1; bus.mem_result = 32'hDEAD;
        bus.wb_rd = 0; bus.wb_reg_write = 1; bus.wb_result = 32'hBEEF; #1;
        chk("x0_op1", bus.ex_op1, 32'd0);
        chk("x0_op2", bus.ex_op2, 32'd0);
        step(); idle();

        // Reset in the middle of a load-use stall
        id_instr(5'd0, 5'd0, 0, 0, 32'h0, 32'h0, 5'd3, 1);
        step();
        id_instr(5'd3, 5'd0, 1, 0, 32'h31, 32'h0, 5'd4, 0); #1;
        chk("mid_stall", 32'(bus.id_stall), 32'd1);
        rst_n = 1'b0; #1;
        chk("mid_rst_valid", 32'(bus.ex_valid), 32'd0);
        chk("mid_rst_stall", 32'(bus.id_stall), 32'd0);
        rst_n = 1'b1;
        step(); #1;
        chk("post_rst_valid", 32'(bus.ex_valid), 32'd1);
        chk("post_rst_op1", bus.ex_op1, 32'h31);
        idle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bus.id_valid      = ($urandom_range(0, 3) != 0);
            bus.id_rs1        = 5'($urandom_range(0, 7));
            bus.id_rs2        = 5'($urandom_range(0, 7));
            bus.id_use1       = $urandom_range(0, 1) == 1;
            bus.id_use2       = $urandom_range(0, 1) == 1;
            bus.id_rd1        = $urandom;
            bus.id_rd2        = $urandom;
            bus.id_rd         = 5'($urandom_range(0, 7));
            bus.id_reg_write  = $urandom_range(0, 1) == 1;
            bus.id_mem_read   = ($urandom_range(0, 2) == 0);
            bus.mem_rd        = 5'($urandom_range(0, 7));
            bus.mem_reg_write = $urandom_range(0, 1) == 1;
            bus.mem_result    = $urandom;
            bus.wb_rd         = 5'($urandom_range(0, 7));
            bus.wb_reg_write  = $urandom_range(0, 1) == 1;
            bus.wb_result     = $urandom;
            bus.ex_hold       = ($urandom_range(0, 5) == 0);
            bus.flush         = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0; #1; rst_n = 1'b1;
            end
            step();
        end

        idle();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
